dht11_emulador: RTL and testbench

- Behavioural-synthesisable DHT11 sensor responder: the sensor end of the single-wire protocol whose host end is the measurement interface in the TUSCA datapath.
- Drives the open-drain dht_bus with a programmable humidity/temperature frame.
- Used on FPGA and in benches to exercise the DHT11 host without a physical sensor, including error injection (absent sensor, bad checksum).

---
 rtl/dht11_emulador.sv | 175 +++++++++++++++++
 tb/tb_dht11_emulador.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_emulador.sv
`default_nettype none
// ============================================================================
// Module   : dht11_emulador
// Brief    : Sensor end of the DHT11 single-wire protocol, open-drain bus.
// Revision : 1.0 - initial release
// ============================================================================
module dht11_emulador #(
  parameter int CICLOS_US      = 50,
  parameter int T_START_MIN_US = 18000,
  parameter int T_ESPERA_US    = 30,
  parameter int T_RESPOSTA_US  = 80,
  parameter int T_BIT_BAIXO_US = 50,
  parameter int T_ZERO_US      = 27,
  parameter int T_UM_US        = 70
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire         dht_bus,
  input  logic        habilita,
  input  logic [15:0] umidade,
  input  logic [15:0] temperatura,
  input  logic        corrompe_checksum,
  output logic        ocupado,
  output logic        pronto,
  output logic [7:0]  num_respostas,
  output logic [2:0]  db_estado
);

  localparam int c_START     = T_START_MIN_US * CICLOS_US;
  localparam int c_ESPERA    = T_ESPERA_US * CICLOS_US;
  localparam int c_RESP      = T_RESPOSTA_US * CICLOS_US;
  localparam int c_BIT_BAIXO = T_BIT_BAIXO_US * CICLOS_US;
  localparam int c_ZERO      = T_ZERO_US * CICLOS_US;
  localparam int c_UM        = T_UM_US * CICLOS_US;
  localparam int c_MAX_A     = (c_START > c_ESPERA) ? c_START : c_ESPERA;
  localparam int c_MAX_B     = (c_RESP > c_BIT_BAIXO) ? c_RESP : c_BIT_BAIXO;
  localparam int c_MAX_C     = (c_ZERO > c_UM) ? c_ZERO : c_UM;
  localparam int c_MAX_AB    = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int c_MAX       = (c_MAX_AB > c_MAX_C) ? c_MAX_AB : c_MAX_C;
  localparam int c_CW        = $clog2(c_MAX + 1);

  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    DETECTA    = 3'd1,
    ESPERA     = 3'd2,
    RESP_BAIXO = 3'd3,
    RESP_ALTO  = 3'd4,
    BIT_BAIXO  = 3'd5,
    BIT_ALTO   = 3'd6,
    FIM        = 3'd7
  } estado_t;

  estado_t         r_estado;
  estado_t         w_prox;
  logic [c_CW-1:0] r_cont;
  logic [c_CW-1:0] w_dur;
  logic            r_bus_m;
  logic            r_bus_s;
  logic            r_armado;
  logic [39:0]     r_quadro;
  logic [5:0]      r_nbit;
  logic [7:0]      w_chk;
  logic            w_fim_fase;
  logic            w_valido;
  logic            w_baixo;

  assign w_chk      = (umidade[15:8] + umidade[7:0] + temperatura[15:8] + temperatura[7:0])
                      ^ {7'd0, corrompe_checksum};
  assign w_fim_fase = (r_cont == w_dur - 1'b1);
  assign w_valido   = (r_cont >= c_CW'(c_START));
  assign dht_bus    = w_baixo ? 1'b0 : 1'bz;
  assign db_estado  = r_estado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox;
    end
  end

  always_comb begin
    w_prox  = r_estado;
    w_dur   = '0;
    w_baixo = 1'b0;
    ocupado = 1'b0;
    case (r_estado)
      OCIOSO: begin
        // r_armado guarantees a high was seen, so the tail of FIM never restarts us
        if (!r_bus_s && habilita && r_armado) w_prox = DETECTA;
      end
      DETECTA: begin
        if (r_bus_s) w_prox = w_valido ? ESPERA : OCIOSO;
      end
      ESPERA: begin
        ocupado = 1'b1;
        w_dur   = c_CW'(c_ESPERA);
        if (w_fim_fase) w_prox = RESP_BAIXO;
      end
      RESP_BAIXO: begin
        ocupado = 1'b1;
        w_baixo = 1'b1;
        w_dur   = c_CW'(c_RESP);
        if (w_fim_fase) w_prox = RESP_ALTO;
      end
      RESP_ALTO: begin
        ocupado = 1'b1;
        w_dur   = c_CW'(c_RESP);
        if (w_fim_fase) w_prox = BIT_BAIXO;
      end
      BIT_BAIXO: begin
        ocupado = 1'b1;
        w_baixo = 1'b1;
        w_dur   = c_CW'(c_BIT_BAIXO);
        if (w_fim_fase) w_prox = BIT_ALTO;
      end
      BIT_ALTO: begin
        ocupado = 1'b1;
        w_dur   = r_quadro[39] ? c_CW'(c_UM) : c_CW'(c_ZERO);
        if (w_fim_fase) w_prox = (r_nbit == 6'd39) ? FIM : BIT_BAIXO;
      end
      FIM: begin
        ocupado = 1'b1;
        w_baixo = 1'b1;
        w_dur   = c_CW'(c_BIT_BAIXO);
        if (w_fim_fase) w_prox = OCIOSO;
      end
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bus_m       <= 1'b1;
      r_bus_s       <= 1'b1;
      r_armado      <= 1'b0;
      r_cont        <= '0;
      r_quadro      <= '0;
      r_nbit        <= '0;
      pronto        <= 1'b0;
      num_respostas <= '0;
    end else begin
      r_bus_m  <= dht_bus;
      r_bus_s  <= r_bus_m;
      r_armado <= (r_estado == OCIOSO) && r_bus_s;
      pronto   <= 1'b0;

      // DETECTA starts at 1 because the low that triggered it is already one cycle
      if (w_prox != r_estado) begin
        r_cont <= (w_prox == DETECTA) ? c_CW'(1) : '0;
      end else if (r_estado == DETECTA) begin
        if (!r_bus_s && !w_valido) r_cont <= r_cont + 1'b1;
      end else if (r_estado != OCIOSO) begin
        r_cont <= r_cont + 1'b1;
      end

      if (r_estado == DETECTA && w_prox == ESPERA) begin
        r_quadro <= {umidade, temperatura, w_chk};
        r_nbit   <= '0;
      end

      if (r_estado == BIT_ALTO && w_fim_fase) begin
        r_quadro <= {r_quadro[38:0], 1'b0};
        r_nbit   <= r_nbit + 1'b1;
      end

      if (r_estado == FIM && w_fim_fase) begin
        pronto        <= 1'b1;
        num_respostas <= num_respostas + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dht11_emulador.sv
`default_nettype none
// ============================================================================
// Module   : tb_dht11_emulador
// Brief    : Host-side stimulus and cycle-level protocol model for dht11_emulador.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dht11_emulador;

  localparam int CICLOS_US      = 1;
  localparam int T_START_MIN_US = 18;
  localparam int T_ESPERA_US    = 3;
  localparam int T_RESPOSTA_US  = 8;
  localparam int T_BIT_BAIXO_US = 5;
  localparam int T_ZERO_US      = 2;
  localparam int T_UM_US        = 7;

  localparam int E  = T_ESPERA_US * CICLOS_US;
  localparam int R  = T_RESPOSTA_US * CICLOS_US;
  localparam int B  = T_BIT_BAIXO_US * CICLOS_US;
  localparam int HZ = T_ZERO_US * CICLOS_US;
  localparam int HU = T_UM_US * CICLOS_US;
  localparam int TS = T_START_MIN_US * CICLOS_US;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        host_low = 1'b0;
  logic        habilita = 1'b1;
  logic [15:0] umidade = '0;
  logic [15:0] temperatura = '0;
  logic        corrompe_checksum = 1'b0;
  logic        ocupado;
  logic        pronto;
  logic [7:0]  num_respostas;
  logic [2:0]  db_estado;
  wire         dht_bus;

  pullup (dht_bus);
  assign dht_bus = host_low ? 1'b0 : 1'bz;

  always #5 clock = ~clock;

  dht11_emulador #(
    .CICLOS_US(CICLOS_US), .T_START_MIN_US(T_START_MIN_US), .T_ESPERA_US(T_ESPERA_US),
    .T_RESPOSTA_US(T_RESPOSTA_US), .T_BIT_BAIXO_US(T_BIT_BAIXO_US),
    .T_ZERO_US(T_ZERO_US), .T_UM_US(T_UM_US)
  ) dut (
    .clock(clock), .reset(reset), .dht_bus(dht_bus), .habilita(habilita),
    .umidade(umidade), .temperatura(temperatura), .corrompe_checksum(corrompe_checksum),
    .ocupado(ocupado), .pronto(pronto), .num_respostas(num_respostas), .db_estado(db_estado)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          pronto_cnt = 0;
  logic        in_reset = 1'b1;
  logic        frame_active = 1'b0;
  int          f_start = 0;
  int          f_end = 0;
  logic [39:0] f_bits = '0;
  logic [7:0]  exp_count = '0;
  logic        wave[$];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (cyc > 150000) begin
      $display("FAIL watchdog: cycle %0d exceeds budget 150000", cyc);
      $fatal(1);
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int h_of(input logic b);
    return b ? HU : HZ;
  endfunction

  function automatic int frame_len(input logic [39:0] bits);
    int s;
    s = E + 2 * R + B;
    for (int i = 39; i >= 0; i--) s += B + h_of(bits[i]);
    return s;
  endfunction

  // Protocol phase at a given offset from the start of ESPERA
  function automatic logic [2:0] seg_state(input int off, input logic [39:0] bits);
    logic [2:0] st;
    int t;
    st = 3'd7;
    t  = E + 2 * R;
    if (off < E) st = 3'd2;
    else if (off < E + R) st = 3'd3;
    else if (off < t) st = 3'd4;
    else begin
      for (int i = 39; i >= 0; i--) begin
        if (st == 3'd7 && off < t + B) st = 3'd5;
        else if (st == 3'd7 && off < t + B + h_of(bits[i])) st = 3'd6;
        t += B + h_of(bits[i]);
      end
    end
    return st;
  endfunction

  always @(negedge clock) begin
    int n;
    logic busy, exp_bus, exp_pronto;
    logic [2:0] st;
    if (!in_reset) begin
      n          = cyc;
      busy       = frame_active && n >= f_start && n < f_end;
      st         = busy ? seg_state(n - f_start, f_bits) : 3'd0;
      exp_bus    = !(host_low || (busy && (st == 3'd3 || st == 3'd5 || st == 3'd7)));
      exp_pronto = frame_active && n == f_end;
      if (exp_pronto) exp_count = exp_count + 8'd1;
      if (busy) wave.push_back(dht_bus);
      check("bus", dht_bus, exp_bus);
      check("ocupado", ocupado, busy);
      check("pronto", pronto, exp_pronto);
      check("num_respostas", num_respostas, exp_count);
      if (busy) check("db_estado", db_estado, st);
      if (pronto === 1'b1) pronto_cnt++;
      if (exp_pronto) frame_active = 1'b0;
    end
  end

  task automatic host_start(input int len);
    logic [7:0] s;
    @(posedge clock);
    #1 host_low = 1'b1;
    repeat (len) @(posedge clock);
    #1 host_low = 1'b0;
    if (habilita && len >= TS) begin
      s = umidade[15:8] + umidade[7:0] + temperatura[15:8] + temperatura[7:0];
      s = s ^ {7'd0, corrompe_checksum};
      f_bits  = {umidade, temperatura, s};
      f_start = cyc + 3;
      f_end   = f_start + frame_len(f_bits);
      wave.delete();
      frame_active = 1'b1;
    end
  endtask

  task automatic wait_frame();
    int k;
    k = 0;
    while (frame_active && k < 1000) begin
      @(negedge clock);
      k++;
    end
    check("frame_timeout", frame_active, 1'b0);
    repeat (2) @(posedge clock);
  endtask

  task automatic decode_check(input logic [39:0] exp_bits);
    int runs[$];
    int len, bad;
    logic cur;
    logic [39:0] got;
    len = 0; bad = 0; got = '0; cur = 1'b1;
    foreach (wave[i]) begin
      if (i > 0 && wave[i] !== cur) begin
        runs.push_back(len);
        len = 0;
      end
      cur = wave[i];
      len++;
    end
    if (len > 0) runs.push_back(len);
    check("n_runs", runs.size(), 84);
    if (runs.size() == 84) begin
      check("resp_low", runs[1], R);
      check("resp_high", runs[2], R);
      for (int i = 0; i < 40; i++) begin
        if (runs[3 + 2 * i] != B) bad++;
        got = {got[38:0], runs[4 + 2 * i] > 4};
      end
      check("bit_lows", bad, 0);
      check("final_low", runs[83], B);
      check("frame_bytes", got, exp_bits);
    end
  endtask

  initial begin
    int target;
    repeat (3) @(posedge clock);
    #1;
    check("rst_bus", dht_bus, 1'b1);
    check("rst_ocupado", ocupado, 1'b0);
    check("rst_pronto", pronto, 1'b0);
    check("rst_num", num_respostas, 8'd0);
    check("rst_estado", db_estado, 3'd0);
    #1 reset = 1'b1;
    in_reset = 1'b0;

    // nominal frame
    umidade = 16'h3C00; temperatura = 16'h1905; corrompe_checksum = 1'b0;
    pronto_cnt = 0;
    host_start(20);
    wait_frame();
    decode_check(40'h3C00_1905_5A);
    check("nominal_pronto_pulses", pronto_cnt, 1);
    check("nominal_num", num_respostas, 8'd1);

    // corrupted checksum
    corrompe_checksum = 1'b1;
    host_start(20);
    wait_frame();
    decode_check(40'h3C00_1905_5B);
    corrompe_checksum = 1'b0;

    // short starts, including one cycle below the threshold
    host_start(10);
    repeat (40) @(negedge clock);
    check("short10_estado", db_estado, 3'd0);
    host_start(TS - 1);
    repeat (40) @(negedge clock);
    check("short17_estado", db_estado, 3'd0);

    // sensor absent
    habilita = 1'b0;
    host_start(20);
    repeat (60) @(negedge clock);
    check("absent_estado", db_estado, 3'd0);
    check("absent_num", num_respostas, 8'd2);
    habilita = 1'b1;
    repeat (3) @(posedge clock);

    for (int f = 0; f < 3; f++) begin
      umidade = 16'($urandom); temperatura = 16'($urandom);
      corrompe_checksum = 1'($urandom_range(0, 1));
      host_start(int'($urandom_range(TS, TS + 7)));
      wait_frame();
    end

    // reset during the low phase of bit 12
    umidade = 16'h3C00; temperatura = 16'h1905; corrompe_checksum = 1'b0;
    host_start(20);
    target = f_start + E + 2 * R + 2;
    for (int i = 0; i < 12; i++) target += B + h_of(f_bits[39 - i]);
    while (cyc < target) @(negedge clock);
    check("pre_reset_estado", db_estado, 3'd5);
    #2 reset = 1'b0;
    in_reset = 1'b1;
    frame_active = 1'b0;
    exp_count = '0;
    #1;
    check("midrst_bus", dht_bus, 1'b1);
    check("midrst_num", num_respostas, 8'd0);
    check("midrst_ocupado", ocupado, 1'b0);
    @(posedge clock);
    #2 reset = 1'b1;
    in_reset = 1'b0;
    repeat (2) @(posedge clock);

    // 256 back-to-back frames; inputs change mid-frame for the following one
    for (int f = 0; f < 256; f++) begin
      host_start(TS);
      repeat (100) @(negedge clock);
      habilita = 1'b0;
      if (f % 64 == 1) begin
        umidade = 16'($urandom); temperatura = 16'($urandom);
      end else begin
        umidade = {8'd0, 8'($urandom_range(0, 1))}; temperatura = 16'd0;
      end
      corrompe_checksum = 1'($urandom_range(0, 1));
      if (f % 32 == 7) begin
        @(posedge clock);
        #1 host_low = 1'b1;
        repeat (5) @(posedge clock);
        #1 host_low = 1'b0;
      end
      repeat (50) @(negedge clock);
      habilita = 1'b1;
      wait_frame();
      if (f == 0) decode_check(40'h3C00_1905_5A);
    end
    check("wrap_num", num_respostas, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
